// File: rtl/nios2system_pio_in_if.sv
// Avalon-MM slave bus bundle for the input PIO: register select, write strobe/data and read data.
interface nios2system_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios2system_pio_in.sv
// Input PIO for the Nios II: synchroniser, optional debounce, edge capture, masked level IRQ.
// Debounce counters exist only when NIOS2SYSTEM_PIO_IN_DEBOUNCE_EN is defined.
module nios2system_pio_in #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nios2system_pio_in_if.slave  bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2 || EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_cfg
    $error("nios2system_pio_in: illegal parameter combination");
  end

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] stable, stable_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edgecapture, irqmask;
  logic [WIDTH-1:0] clr;
  logic             wr_strobe;
  logic             wd_unused;

  // Upper writedata bits are never stored; fold them away explicitly.
  assign wd_unused = ^bus.writedata;
  assign wr_strobe = bus.chipselect && !bus.write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef NIOS2SYSTEM_PIO_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] count [WIDTH];

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          count[i] <= '0;
        end else if (count[i] == LAST) begin
          stable[i] <= sync2[i];
          count[i]  <= '0;
        end else begin
          count[i] <= count[i] + 1'b1;
        end
      end
    end
  end
`else
  assign stable = sync2;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stable_d <= '0;
    else          stable_d <= stable;
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_hit = stable & ~stable_d;
      1:       edge_hit = ~stable & stable_d;
      default: edge_hit = stable ^ stable_d;
    endcase
  end

  always_comb begin
    clr = '0;
    if (wr_strobe && bus.address == 2'd3) clr = bus.writedata[WIDTH-1:0];
  end

  // A new edge is OR-ed in after the clear so a simultaneous W1C never loses it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
      irqmask     <= '0;
      irq         <= 1'b0;
    end else begin
      edgecapture <= (edgecapture & ~clr) | edge_hit;
      if (wr_strobe && bus.address == 2'd2) irqmask <= bus.writedata[WIDTH-1:0];
      irq <= |(edgecapture & irqmask);
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata[WIDTH-1:0] = stable;
      2'd2:    bus.readdata[WIDTH-1:0] = irqmask;
      2'd3:    bus.readdata[WIDTH-1:0] = edgecapture;
      default: bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios2system_pio_in.sv
// Bench for nios2system_pio_in: table of single-step vectors on a rising-edge instance plus
// hand sequences for glitch rejection, set-vs-clear, any-edge capture and asynchronous reset.
module tb_nios2system_pio_in;

  localparam int DB = 4;
`ifdef NIOS2SYSTEM_PIO_IN_DEBOUNCE_EN
  localparam int SETTLE = 2 + DB;
`else
  localparam int SETTLE = 2;
`endif

  typedef struct {
    bit          wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  inp;
    int          cycles;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] in_a, in_b;
  logic       irq_a, irq_b;
  int         checks = 0;
  int         failures = 0;
  vec_t       vecs[$];

  nios2system_pio_in_if bus_a ();
  nios2system_pio_in_if bus_b ();

  nios2system_pio_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DB)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_a), .irq(irq_a));

  nios2system_pio_in #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DB)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .in_port(in_b), .irq(irq_b));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic busWrite(input int sel, input logic [1:0] a, input logic [31:0] d);
    if (sel == 0) begin
      bus_a.address = a; bus_a.writedata = d; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
    end else begin
      bus_b.address = a; bus_b.writedata = d; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
    end
    tick(1);
    bus_a.write_n = 1'b1; bus_a.chipselect = 1'b0;
    bus_b.write_n = 1'b1; bus_b.chipselect = 1'b0;
  endtask

  task automatic checkOutput(input int sel, input logic [1:0] a, input logic [31:0] exp_rd,
                             input logic exp_irq, input string tag);
    logic [31:0] rd;
    logic        iq;
    if (sel == 0) begin bus_a.address = a; bus_a.chipselect = 1'b1; end
    else          begin bus_b.address = a; bus_b.chipselect = 1'b1; end
    #1;
    rd = (sel == 0) ? bus_a.readdata : bus_b.readdata;
    iq = (sel == 0) ? irq_a : irq_b;
    checks++;
    if (rd !== exp_rd) begin
      failures++;
      $display("[TB] FAIL %s readdata@%0d got=0x%08h want=0x%08h", tag, a, rd, exp_rd);
    end
    checks++;
    if (iq !== exp_irq) begin
      failures++;
      $display("[TB] FAIL %s irq got=%b want=%b", tag, iq, exp_irq);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    in_a = v.inp;
    for (int c = 0; c < v.cycles; c++) begin
      if (c == 0 && v.wr) busWrite(0, v.waddr, v.wdata);
      else                tick(1);
    end
  endtask

  task automatic addVec(input bit wr, input logic [1:0] wa, input logic [31:0] wd, input logic [3:0] inp,
                        input int cyc, input logic [1:0] ra, input logic [31:0] er, input logic ei);
    vec_t v;
    v.wr = wr; v.waddr = wa; v.wdata = wd; v.inp = inp;
    v.cycles = cyc; v.raddr = ra; v.exp_rd = er; v.exp_irq = ei;
    vecs.push_back(v);
  endtask

  initial begin
    // Vectors run back to back on dut_a; each row drives, steps 'cycles' edges, then reads.
    addVec(0, 0, 0,            4'h0, 0,          0, 32'h0, 0);
    addVec(0, 0, 0,            4'h0, 0,          2, 32'h0, 0);
    addVec(0, 0, 0,            4'h0, 0,          3, 32'h0, 0);
    addVec(0, 0, 0,            4'h0, 0,          1, 32'h0, 0);
    addVec(1, 2, 32'h1,        4'h0, 1,          2, 32'h1, 0);
    addVec(0, 0, 0,            4'h1, SETTLE - 1, 0, 32'h0, 0);
    addVec(0, 0, 0,            4'h1, 1,          0, 32'h1, 0);
    addVec(0, 0, 0,            4'h1, 0,          3, 32'h0, 0);
    addVec(0, 0, 0,            4'h1, 1,          3, 32'h1, 0);
    addVec(0, 0, 0,            4'h1, 1,          3, 32'h1, 1);
    addVec(1, 3, 32'h1,        4'h1, 1,          3, 32'h0, 1);
    addVec(0, 0, 0,            4'h1, 1,          3, 32'h0, 0);
    addVec(0, 0, 0,            4'h1, 0,          0, 32'h1, 0);
    addVec(1, 1, 32'hFFFFFFFF, 4'h1, 1,          1, 32'h0, 0);
    addVec(1, 0, 32'hF,        4'h1, 1,          0, 32'h1, 0);
    addVec(1, 2, 32'h0,        4'h1, 1,          2, 32'h0, 0);
    addVec(0, 0, 0,            4'h3, SETTLE + 2, 3, 32'h2, 0);
    addVec(1, 2, 32'h2,        4'h3, 1,          2, 32'h2, 0);
    addVec(0, 0, 0,            4'h3, 1,          2, 32'h2, 1);
    addVec(1, 2, 32'h0,        4'h3, 1,          3, 32'h2, 1);
    addVec(0, 0, 0,            4'h3, 1,          3, 32'h2, 0);
    addVec(1, 3, 32'h0,        4'h3, 1,          3, 32'h2, 0);
    addVec(1, 3, 32'h2,        4'h3, 1,          3, 32'h0, 0);
    addVec(0, 0, 0,            4'h0, SETTLE + 2, 3, 32'h0, 0);
    addVec(0, 0, 0,            4'h0, 0,          0, 32'h0, 0);
    addVec(1, 2, 32'hFFFFFFFF, 4'h0, 1,          2, 32'hF, 0);

    in_a = 4'h0; in_b = 4'h0; reset_n = 1'b0;
    bus_a.address = 2'd0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    bus_b.address = 2'd0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(0, vecs[i].raddr, vecs[i].exp_rd, vecs[i].exp_irq, $sformatf("vec%0d", i));
    end

`ifdef NIOS2SYSTEM_PIO_IN_DEBOUNCE_EN
    // A 3-cycle pulse is one short of the debounce window and must vanish.
    in_a = 4'h4;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checkOutput(0, 0, 32'h0, 0, "glitch_data");
    end
    in_a = 4'h0;
    tick(SETTLE + 2);
    checkOutput(0, 0, 32'h0, 0, "glitch_data_after");
    checkOutput(0, 3, 32'h0, 0, "glitch_ec");
`endif

    // Capture edge of bit 3 coincides with a W1C of bit 3.
    in_a = 4'h8;
    tick(SETTLE);
    busWrite(0, 3, 32'h8);
    checkOutput(0, 3, 32'h8, 0, "set_vs_clr");
    tick(1);
    checkOutput(0, 3, 32'h8, 1, "set_vs_clr_irq");
    busWrite(0, 3, 32'h8);
    checkOutput(0, 3, 32'h0, 1, "clr3");
    tick(1);
    checkOutput(0, 3, 32'h0, 0, "clr3_irq");

    // Any-edge instance: both rise and fall are captured.
    in_b = 4'h4;
    tick(SETTLE);
    checkOutput(1, 3, 32'h0, 0, "any_rise_early");
    tick(1);
    checkOutput(1, 3, 32'h4, 0, "any_rise");
    checkOutput(1, 0, 32'h4, 0, "any_data_hi");
    busWrite(1, 3, 32'h4);
    checkOutput(1, 3, 32'h0, 0, "any_clr");
    in_b = 4'h0;
    tick(SETTLE + 1);
    checkOutput(1, 3, 32'h4, 0, "any_fall");
    checkOutput(1, 0, 32'h0, 0, "any_data_lo");
    busWrite(1, 2, 32'h4);
    checkOutput(1, 3, 32'h4, 0, "any_mask_same");
    tick(1);
    checkOutput(1, 3, 32'h4, 1, "any_irq");

    // Asynchronous reset in the middle of a pending debounce.
    in_b = 4'h4;
    tick(1);
    reset_n = 1'b0;
    #1;
    checkOutput(1, 3, 32'h0, 0, "rst_b_ec");
    checkOutput(1, 2, 32'h0, 0, "rst_b_mask");
    checkOutput(1, 0, 32'h0, 0, "rst_b_data");
    checkOutput(0, 0, 32'h0, 0, "rst_a_data");
    checkOutput(0, 2, 32'h0, 0, "rst_a_mask");
    reset_n = 1'b1;
    tick(SETTLE);
    checkOutput(0, 3, 32'h0, 0, "post_rst_a_early");
    checkOutput(1, 3, 32'h0, 0, "post_rst_b_early");
    tick(1);
    checkOutput(0, 3, 32'h8, 0, "post_rst_a_cap");
    checkOutput(1, 3, 32'h4, 0, "post_rst_b_cap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
